imem_line_buffer: RTL and testbench

IMEM_LINE_BUFFER -- requirements
Module: imem_line_buffer

---
 rtl/imem_line_buffer.sv | 107 ++++++++++
 tb/tb_imem_line_buffer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_line_buffer.sv
// Single-line instruction fetch buffer. It holds one 32-byte line and answers hits
// combinationally. On a miss it bursts the line in from backing memory as four
// 64-bit beats.
module imem_line_buffer #(
    parameter int unsigned LINE_BEATS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [63:0] imem_rdata,
    output logic        imem_resp,
    output logic        imem_stall,
    output logic [31:0] bmem_addr,
    output logic        bmem_read,
    input  logic        bmem_ready,
    input  logic        bmem_rvalid,
    input  logic [63:0] bmem_rdata
);

    localparam int unsigned CntW = $clog2(LINE_BEATS);

    typedef enum logic [1:0] {StIdle, StReq, StFill} state_e;

    state_e          r_state;
    logic            r_valid;
    logic [26:0]     r_tag;
    logic [26:0]     r_fill_tag;
    logic [CntW-1:0] r_cnt;
    logic            r_bmem_read;
    logic [63:0]     r_data [LINE_BEATS];

    logic w_req;
    logic w_hit;
    logic w_last_beat;
    logic w_unused_addr;

    // Lookup is only trusted in idle; during a fill the line contents are in flux.
    always_comb begin
        w_req       = |imem_rmask;
        w_hit       = w_req && (r_state == StIdle) && r_valid && (r_tag == imem_addr[31:5]);
        w_last_beat = (r_cnt == CntW'(LINE_BEATS - 1));
    end

    // Fetch-side and memory-side outputs; handshakes are held low while reset is high.
    always_comb begin
        imem_resp  = !rst && w_hit;
        imem_stall = !rst && w_req && !w_hit;
        imem_rdata = r_data[imem_addr[4:3]];
        bmem_addr  = {r_fill_tag, 5'b0};
        bmem_read  = !rst && r_bmem_read;
    end

    // The low address bits select a byte inside a 64-bit beat; the buffer does not use them.
    assign w_unused_addr = ^imem_addr[2:0];

    // Control FSM: miss detection, burst request handshake, and beat counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_valid     <= 1'b0;
            r_cnt       <= '0;
            r_bmem_read <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_req && !w_hit) begin
                        r_fill_tag  <= imem_addr[31:5];
                        r_valid     <= 1'b0;
                        r_cnt       <= '0;
                        r_bmem_read <= 1'b1;
                        r_state     <= StReq;
                    end
                end
                StReq: begin
                    if (bmem_ready) begin
                        r_bmem_read <= 1'b0;
                        r_state     <= StFill;
                    end
                end
                StFill: begin
                    // A redirect of imem_addr does not cancel the burst; idle re-checks later.
                    if (bmem_rvalid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last_beat) begin
                            r_valid <= 1'b1;
                            r_tag   <= r_fill_tag;
                            r_state <= StIdle;
                        end
                    end
                end
                default: begin
                    r_state     <= StIdle;
                    r_bmem_read <= 1'b0;
                end
            endcase
        end
    end

    // Line storage: valid protects it, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == StFill) && bmem_rvalid) begin
            r_data[r_cnt] <= bmem_rdata;
        end
    end

endmodule

// File: tb/tb_imem_line_buffer.sv
// Bench for imem_line_buffer. It combines a directed vector table, hand-written
// multi-cycle sequences and randomized traffic. All of it is checked against a
// transaction-level model of the line buffer.
module tb_imem_line_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [63:0] imem_rdata;
    logic        imem_resp;
    logic        imem_stall;
    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_ready;
    logic        bmem_rvalid;
    logic [63:0] bmem_rdata;

    imem_line_buffer #(.LINE_BEATS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rmask  (imem_rmask),
        .imem_rdata  (imem_rdata),
        .imem_resp   (imem_resp),
        .imem_stall  (imem_stall),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_ready  (bmem_ready),
        .bmem_rvalid (bmem_rvalid),
        .bmem_rdata  (bmem_rdata)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Memory responder state
    int          beats_left  = 0;
    logic [26:0] mem_line    = '0;
    int          ready_stall = 0;
    bit          ready_rand  = 1'b0;
    int          gap_pct     = 0;
    int          n_hs        = 0;
    logic [31:0] hs_addr     = '0;

    // Reference model: cached line identity plus the outstanding burst, if any
    bit          m_valid = 1'b0;
    logic [26:0] m_tag   = '0;
    bit          m_pend  = 1'b0;
    bit          m_acc   = 1'b0;
    logic [26:0] m_line  = '0;
    int          m_beats = 0;

    // Outputs observed in the most recent tick
    logic        s_resp;
    logic        s_stall;
    logic        s_read;
    logic [31:0] s_baddr;
    logic [63:0] s_rdata;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic        resp;
        logic        stall;
        logic        rd;
        logic [63:0] rdata;
    } vec_t;

    vec_t tbl [12];

    // Backing store contents; line 0x6000_0000 uses a recognisable 0x11..0x44 pattern.
    function automatic logic [63:0] mem_beat(input logic [26:0] line, input int k);
        logic [7:0]  b;
        logic [31:0] h;
        if (line == 27'h300_0000) begin
            b = 8'(17 * (k + 1));
            return {8{b}};
        end
        h = 32'({5'b0, line} * 32'h9E37_79B9) + 32'(k);
        return {5'(k), line, h};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive memory inputs, compare to the model, then advance model and memory.
    task automatic tick();
        logic req;
        logic hit;
        logic e_resp;
        logic e_stall;
        logic e_read;
        if (ready_rand) bmem_ready = 1'($urandom_range(1));
        else            bmem_ready = (ready_stall == 0);
        if (beats_left > 0 && int'($urandom_range(99)) >= gap_pct) begin
            bmem_rvalid = 1'b1;
            bmem_rdata  = mem_beat(mem_line, 4 - beats_left);
        end else begin
            bmem_rvalid = 1'b0;
            bmem_rdata  = {$urandom, $urandom};
        end
        #2;
        req     = |imem_rmask;
        hit     = req && !m_pend && m_valid && (m_tag == imem_addr[31:5]);
        e_resp  = !rst && hit;
        e_stall = !rst && req && !hit;
        e_read  = !rst && m_pend && !m_acc;
        chk("resp", 64'(imem_resp), 64'(e_resp));
        chk("stall", 64'(imem_stall), 64'(e_stall));
        chk("bmem_read", 64'(bmem_read), 64'(e_read));
        if (e_read) chk("bmem_addr", 64'(bmem_addr), 64'({m_line, 5'b0}));
        if (e_resp) chk("rdata", imem_rdata, mem_beat(m_tag, int'(imem_addr[4:3])));
        s_resp  = imem_resp;
        s_stall = imem_stall;
        s_read  = bmem_read;
        s_baddr = bmem_addr;
        s_rdata = imem_rdata;
        if (rst) begin
            m_valid = 1'b0;
            m_pend  = 1'b0;
        end else if (!m_pend) begin
            if (req && !hit) begin
                m_pend  = 1'b1;
                m_acc   = 1'b0;
                m_line  = imem_addr[31:5];
                m_valid = 1'b0;
                m_beats = 0;
            end
        end else if (!m_acc) begin
            if (bmem_ready) m_acc = 1'b1;
        end else if (bmem_rvalid) begin
            m_beats++;
            if (m_beats == 4) begin
                m_valid = 1'b1;
                m_tag   = m_line;
                m_pend  = 1'b0;
            end
        end
        if (bmem_read && bmem_ready) begin
            mem_line   = bmem_addr[31:5];
            beats_left = 4;
            n_hs++;
            hs_addr    = bmem_addr;
        end else if (bmem_rvalid) begin
            beats_left--;
        end
        if (bmem_read && ready_stall > 0) ready_stall--;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [31:0] a, input logic [3:0] m);
        imem_addr  = a;
        imem_rmask = m;
    endtask

    // Ticks until a response; returns the tick count, or -1 if the budget runs out.
    task automatic wait_resp(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (s_resp) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int reads;
        int hs0;
        rst         = 1'b1;
        bmem_ready  = 1'b0;
        bmem_rvalid = 1'b0;
        bmem_rdata  = '0;
        set_req(32'h6000_0000, 4'hF);
        @(posedge clk);
        #1;
        tick();
        tick();
        rst = 1'b0;

        // Directed table: cold miss, hits on each word, idle cycles
        tbl[0]  = '{32'h6000_0000, 4'hF, 1'b0, 1'b1, 1'b0, 64'h0};
        tbl[1]  = '{32'h6000_0000, 4'hF, 1'b0, 1'b1, 1'b1, 64'h0};
        tbl[2]  = '{32'h6000_0000, 4'hF, 1'b0, 1'b1, 1'b0, 64'h0};
        tbl[3]  = '{32'h6000_0000, 4'hF, 1'b0, 1'b1, 1'b0, 64'h0};
        tbl[4]  = '{32'h6000_0000, 4'hF, 1'b0, 1'b1, 1'b0, 64'h0};
        tbl[5]  = '{32'h6000_0000, 4'hF, 1'b0, 1'b1, 1'b0, 64'h0};
        tbl[6]  = '{32'h6000_0000, 4'hF, 1'b1, 1'b0, 1'b0, 64'h1111_1111_1111_1111};
        tbl[7]  = '{32'h6000_0018, 4'hF, 1'b1, 1'b0, 1'b0, 64'h4444_4444_4444_4444};
        tbl[8]  = '{32'h6000_0008, 4'hF, 1'b1, 1'b0, 1'b0, 64'h2222_2222_2222_2222};
        tbl[9]  = '{32'h1234_5678, 4'h0, 1'b0, 1'b0, 1'b0, 64'h0};
        tbl[10] = '{32'h6000_0014, 4'h1, 1'b1, 1'b0, 1'b0, 64'h3333_3333_3333_3333};
        tbl[11] = '{32'h9ABC_DEF0, 4'h0, 1'b0, 1'b0, 1'b0, 64'h0};
        for (int i = 0; i < 12; i++) begin
            set_req(tbl[i].addr, tbl[i].rmask);
            tick();
            chk($sformatf("tbl%0d_resp", i), 64'(s_resp), 64'(tbl[i].resp));
            chk($sformatf("tbl%0d_stall", i), 64'(s_stall), 64'(tbl[i].stall));
            chk($sformatf("tbl%0d_read", i), 64'(s_read), 64'(tbl[i].rd));
            if (tbl[i].rd) chk($sformatf("tbl%0d_baddr", i), 64'(s_baddr), 64'h6000_0000);
            if (tbl[i].resp) chk($sformatf("tbl%0d_rdata", i), s_rdata, tbl[i].rdata);
        end

        // Backpressure: ready low for three cycles of the request
        ready_stall = 3;
        set_req(32'h4000_0040, 4'hF);
        tick();
        reads = 0;
        n     = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (s_read) begin
                reads++;
                chk("bp_addr", 64'(s_baddr), 64'h4000_0040);
            end
            if (s_resp) begin
                n = i;
                break;
            end
        end
        chk("bp_read_cycles", 64'(reads), 64'd4);
        chk("bp_latency", 64'(n), 64'd9);

        // Redirect mid-fill: the first burst completes, then a new miss is raised
        hs0 = n_hs;
        set_req(32'h6000_0040, 4'hF);
        tick();
        tick();
        tick();
        set_req(32'h6000_0100, 4'hF);
        wait_resp(40, n);
        chk("redir_latency", 64'(n), 64'd10);
        chk("redir_bursts", 64'(n_hs - hs0), 64'd2);
        chk("redir_addr", 64'(hs_addr), 64'h6000_0100);

        // Reset after beat 1: stray beats must not complete the line
        set_req(32'h7000_0020, 4'hF);
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(32'h7000_0020, 4'h0);
        tick();
        set_req(32'h7000_0020, 4'hF);
        tick();
        chk("rst_miss_stall", 64'(s_stall), 64'd1);
        chk("rst_miss_resp", 64'(s_resp), 64'd0);
        tick();
        chk("rst_refetch_read", 64'(s_read), 64'd1);
        chk("rst_refetch_addr", 64'(s_baddr), 64'h7000_0020);
        wait_resp(40, n);
        chk("rst_refetch_done", 64'(n > 0), 64'd1);

        // Randomized traffic with gaps, random ready, redirects and occasional reset
        ready_rand = 1'b1;
        gap_pct    = 30;
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] lines [4];
            lines[0] = 32'h6000_0000;
            lines[1] = 32'h6000_0020;
            lines[2] = 32'h1000_0FE0;
            lines[3] = 32'hFFFF_FFE0;
            rst = ($urandom_range(49) == 0);
            if ($urandom_range(3) == 0)
                imem_addr = lines[$urandom_range(3)] | 32'(5'($urandom));
            imem_rmask = ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom_range(15));
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
